tx_uart_ctrl: RTL and testbench

Memory-mapped controller that sits between the CPU data bus and the tx_uart transmitter.
- Buffers outgoing bytes in a small FIFO.
- Paces write_enable pulses to the exact frame time of the transmitter, which has no busy output.
- Serialises baud-rate changes so they never collide with a frame in flight.
- Provides status and a TX-empty interrupt.

---
 rtl/tx_uart_pkg.sv | 57 +++++
 rtl/tx_uart_ctrl_sync_fifo.sv | 46 ++++
 rtl/tx_uart_ctrl.sv | 154 +++++++++++++++
 tb/tb_tx_uart_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_uart_pkg.sv
// Shared definitions for the tx_uart bus controller: baud table, register map,
// STATUS layout and FSM encoding.
package tx_uart_pkg;

  localparam logic [3:0] BAUD_50     = 4'd0;
  localparam logic [3:0] BAUD_110    = 4'd1;
  localparam logic [3:0] BAUD_150    = 4'd2;
  localparam logic [3:0] BAUD_300    = 4'd3;
  localparam logic [3:0] BAUD_1200   = 4'd4;
  localparam logic [3:0] BAUD_2400   = 4'd5;
  localparam logic [3:0] BAUD_4800   = 4'd6;
  localparam logic [3:0] BAUD_9600   = 4'd7;
  localparam logic [3:0] BAUD_19200  = 4'd8;
  localparam logic [3:0] BAUD_38400  = 4'd9;
  localparam logic [3:0] BAUD_57600  = 4'd10;
  localparam logic [3:0] BAUD_115200 = 4'd11;
  localparam logic [3:0] BAUD_230400 = 4'd12;
  localparam logic [3:0] BAUD_460800 = 4'd13;
  localparam logic [3:0] BAUD_500000 = 4'd14;
  localparam logic [3:0] BAUD_MAX    = 4'd15;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CONFIG = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [2:0] {
    ST_GUARD, ST_IDLE, ST_ISSUE_DATA, ST_WAIT_FRAME, ST_ISSUE_CFG
  } state_e;

  // Must stay bit-identical to the transmitter's own table, or pacing drifts.
  function automatic logic [19:0] baud_cycles(input logic [3:0] code);
    case (code)
      BAUD_50:     return 20'd1000000;
      BAUD_110:    return 20'd454545;
      BAUD_150:    return 20'd333333;
      BAUD_300:    return 20'd166666;
      BAUD_1200:   return 20'd41666;
      BAUD_2400:   return 20'd20833;
      BAUD_4800:   return 20'd10416;
      BAUD_9600:   return 20'd5208;
      BAUD_19200:  return 20'd2604;
      BAUD_38400:  return 20'd1302;
      BAUD_57600:  return 20'd868;
      BAUD_115200: return 20'd434;
      BAUD_230400: return 20'd217;
      BAUD_460800: return 20'd108;
      BAUD_500000: return 20'd100;
      default:     return 20'd2;
    endcase
  endfunction

endpackage

// File: rtl/tx_uart_ctrl_sync_fifo.sv
// Byte FIFO for the controller; pointers carry an extra wrap bit so full and
// empty are distinguishable without a counter.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + {{AW{1'b0}}, do_push};
    rd_d    = rd_q + {{AW{1'b0}}, do_pop};
    rdata   = mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tx_uart_ctrl.sv
// Bus-facing controller for tx_uart: queues bytes, spaces write_enable pulses by
// one frame time, and only retunes the baud rate when nothing is in flight.
module tx_uart_ctrl
  import tx_uart_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int RESET_GUARD = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wdata,
  input  logic       bus_we,
  input  logic       bus_re,
  output logic       bus_ready,
  output logic [7:0] bus_rdata,
  output logic [7:0] uart_write_data,
  output logic       uart_write_enable,
  output logic [7:0] uart_config_data,
  output logic       uart_config_enable,
  output logic       irq_tx_empty
);
  state_e      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [31:0] guard_q, guard_d;
  logic [19:0] bit_cycles_q, bit_cycles_d;
  logic [3:0]  baud_code_q, baud_code_d;
  logic [3:0]  pend_cfg_q, pend_cfg_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  rdata_q, rdata_d;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic [7:0]  status;
  logic [23:0] frame;
  logic        cfg_acc;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wdata  (bus_wdata),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    status             = {baud_code_q, 4'b0};
    status[STAT_BUSY]  = (state_q != ST_IDLE);
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_OVF]   = ovf_q;
    frame              = (24'(bit_cycles_q) + 24'd1) * 24'd10;
    irq_tx_empty       = (state_q == ST_IDLE) && fifo_empty;
    bus_rdata          = rdata_q;
  end

  always_comb begin
    state_d            = state_q;
    timer_d            = timer_q;
    guard_d            = guard_q;
    bit_cycles_d       = bit_cycles_q;
    baud_code_d        = baud_code_q;
    pend_cfg_d         = pend_cfg_q;
    ovf_d              = ovf_q;
    rdata_d            = rdata_q;
    fifo_push          = 1'b0;
    fifo_pop           = 1'b0;
    cfg_acc            = 1'b0;
    bus_ready          = 1'b1;
    uart_write_data    = 8'h00;
    uart_write_enable  = 1'b0;
    uart_config_data   = 8'h00;
    uart_config_enable = 1'b0;

    // A write wins over a simultaneous read.
    if (bus_we) begin
      case (bus_addr)
        ADDR_DATA: begin
          if (fifo_full) ovf_d = 1'b1;
          else           fifo_push = 1'b1;
        end
        ADDR_CONFIG: begin
          if (state_q == ST_IDLE && fifo_empty) begin
            cfg_acc    = 1'b1;
            pend_cfg_d = bus_wdata[3:0];
          end else begin
            bus_ready = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (bus_re) begin
      rdata_d = (bus_addr == ADDR_STATUS) ? status : 8'h00;
      if (bus_addr == ADDR_STATUS) ovf_d = 1'b0;
    end

    case (state_q)
      ST_GUARD: begin
        if (guard_q <= 32'd1) state_d = ST_IDLE;
        else                  guard_d = guard_q - 32'd1;
      end
      ST_IDLE: begin
        if (cfg_acc)          state_d = ST_ISSUE_CFG;
        else if (!fifo_empty) state_d = ST_ISSUE_DATA;
      end
      ST_ISSUE_DATA: begin
        uart_write_enable = 1'b1;
        uart_write_data   = fifo_head;
        fifo_pop          = 1'b1;
        timer_d           = frame - 24'd1;
        state_d           = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        // Leaving as the timer reaches zero keeps pulses exactly one frame apart.
        timer_d = timer_q - 24'd1;
        if (timer_q <= 24'd1) state_d = fifo_empty ? ST_IDLE : ST_ISSUE_DATA;
      end
      ST_ISSUE_CFG: begin
        uart_config_enable = 1'b1;
        uart_config_data   = {4'b0, pend_cfg_q};
        baud_code_d        = pend_cfg_q;
        bit_cycles_d       = baud_cycles(pend_cfg_q);
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= (RESET_GUARD > 0) ? ST_GUARD : ST_IDLE;
      timer_q      <= '0;
      guard_q      <= 32'(RESET_GUARD);
      bit_cycles_q <= 20'd2;
      baud_code_q  <= 4'hF;
      pend_cfg_q   <= '0;
      ovf_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      guard_q      <= guard_d;
      bit_cycles_q <= bit_cycles_d;
      baud_code_q  <= baud_code_d;
      pend_cfg_q   <= pend_cfg_d;
      ovf_q        <= ovf_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_tx_uart_ctrl.sv
// Directed bench for tx_uart_ctrl: pacing, overflow, config serialisation,
// reset guard and asynchronous reset.
module tb_tx_uart_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] bus_addr = 2'd0;
  logic [7:0] bus_wdata = 8'h00;
  logic       bus_we = 1'b0, bus_re = 1'b0;
  logic       bus_ready, uart_write_enable, uart_config_enable, irq_tx_empty;
  logic [7:0] bus_rdata, uart_write_data, uart_config_data;

  logic [7:0] g_wdata = 8'h00;
  logic       g_we = 1'b0;
  logic       g_ready, g_we_out, g_cfg_en, g_irq;
  logic [7:0] g_rdata, g_wd_out, g_cfg_data;

  tx_uart_ctrl #(.DEPTH(8), .RESET_GUARD(0)) dut (
    .clk(clk), .reset_n(reset_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .uart_write_data(uart_write_data), .uart_write_enable(uart_write_enable),
    .uart_config_data(uart_config_data), .uart_config_enable(uart_config_enable),
    .irq_tx_empty(irq_tx_empty)
  );

  tx_uart_ctrl #(.DEPTH(8), .RESET_GUARD(100)) dut_g (
    .clk(clk), .reset_n(reset_n), .bus_addr(2'd0), .bus_wdata(g_wdata),
    .bus_we(g_we), .bus_re(1'b0), .bus_ready(g_ready), .bus_rdata(g_rdata),
    .uart_write_data(g_wd_out), .uart_write_enable(g_we_out),
    .uart_config_data(g_cfg_data), .uart_config_enable(g_cfg_en),
    .irq_tx_empty(g_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         we_cyc[$];
  logic [7:0] we_dat[$];
  int         cf_cyc[$];
  logic [7:0] cf_dat[$];
  int         g_cyc[$];

  always @(negedge clk) begin
    if (uart_write_enable) begin we_cyc.push_back(cyc); we_dat.push_back(uart_write_data); end
    if (uart_config_enable) begin cf_cyc.push_back(cyc); cf_dat.push_back(uart_config_data); end
    if (g_we_out) g_cyc.push_back(cyc);
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wc_at(input int i);
    return (i < we_cyc.size()) ? we_cyc[i] : -1;
  endfunction

  function automatic logic [7:0] wd_at(input int i);
    return (i < we_dat.size()) ? we_dat[i] : 8'hxx;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Holds the write until accepted; reports stall cycles and the cycle ready was seen.
  task automatic bwrite(input logic [1:0] a, input logic [7:0] d, output int stall, output int acc);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1; stall = 0;
    #1;
    while (!bus_ready && stall < 5000) begin tick(); stall++; end
    acc = cyc;
    tick();
    bus_we = 1'b0;
  endtask

  task automatic bread(input logic [1:0] a, output logic [7:0] v);
    bus_addr = a; bus_re = 1'b1;
    tick();
    bus_re = 1'b0;
    v = bus_rdata;
  endtask

  task automatic wait_we(input int n, input int lim);
    int t = 0;
    while (we_cyc.size() < n && t < lim) begin tick(); t++; end
  endtask

  task automatic wait_irq(input int lim);
    int t = 0;
    while (!irq_tx_empty && t < lim) begin tick(); t++; end
  endtask

  initial begin
    int st, acc, wc, b, cb, rel, t;
    logic [7:0] v;

    // Reset values
    repeat (3) tick();
    chk("rst_ready", bus_ready, 1);
    chk("rst_irq", irq_tx_empty, 1);
    chk("rst_we", uart_write_enable, 0);
    chk("rst_cfg_en", uart_config_enable, 0);
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_wdata", uart_write_data, 0);
    chk("rst_cfg_data", uart_config_data, 0);
    chk("rst_guard_irq", g_irq, 0);
    reset_n = 1'b1;
    rel = cyc;
    g_wdata = 8'h5A; g_we = 1'b1;
    tick();
    g_we = 1'b0;
    chk("guard_irq_low", g_irq, 0);

    // Single byte
    wc = cyc;
    bwrite(2'd0, 8'h41, st, acc);
    tick();
    chk("single_we", uart_write_enable, 1);
    chk("single_data", uart_write_data, 8'h41);
    bread(2'd2, v);
    chk("status_issue", v, 8'hF1);
    chk("we_one_cycle", uart_write_enable, 0);
    bread(2'd2, v);
    chk("status_wait", v, 8'hF5);
    wait_irq(200);
    chk("single_lat", wc_at(0) - wc, 2);
    chk("irq_after_frame", cyc - wc_at(0), 30);
    chk("guard_irq_still_low", g_irq, 0);

    // Burst of three at default baud
    b = we_cyc.size();
    wc = cyc;
    bwrite(2'd0, 8'h01, st, acc);
    bwrite(2'd0, 8'h02, st, acc);
    bwrite(2'd0, 8'h03, st, acc);
    wait_we(b + 3, 500);
    chk("burst_first", wc_at(b) - wc, 2);
    chk("burst_gap1", wc_at(b + 1) - wc_at(b), 30);
    chk("burst_gap2", wc_at(b + 2) - wc_at(b + 1), 30);
    chk("burst_d0", wd_at(b), 8'h01);
    chk("burst_d1", wd_at(b + 1), 8'h02);
    chk("burst_d2", wd_at(b + 2), 8'h03);
    tick();
    bread(2'd2, v);
    chk("burst_empty", v, 8'hF5);
    wait_irq(200);

    // Reset guard instance
    t = 0;
    while (g_cyc.size() == 0 && t < 300) begin tick(); t++; end
    chk("guard_pulses", g_cyc.size(), 1);
    chk("guard_latency", (g_cyc.size() > 0) && (g_cyc[0] - rel >= 100) && (g_cyc[0] - rel <= 110), 1);

    // Overflow: one in flight, eight buffered, ninth dropped
    b = we_cyc.size();
    bwrite(2'd0, 8'h10, st, acc);
    wait_we(b + 1, 50);
    for (int i = 1; i <= 9; i++) bwrite(2'd0, 8'(8'h10 + i), st, acc);
    chk("ovf_ready", st, 0);
    bread(2'd2, v);
    chk("status_ovf", v, 8'hFB);
    bread(2'd2, v);
    chk("status_ovf_clr", v, 8'hF3);
    wait_we(b + 9, 1000);
    wait_irq(200);
    chk("ovf_count", we_cyc.size(), b + 9);
    for (int i = 0; i < 9; i++) chk("ovf_order", wd_at(b + i), 8'(8'h10 + i));

    // Config while two bytes queued
    b = we_cyc.size();
    cb = cf_cyc.size();
    bwrite(2'd0, 8'hA1, st, acc);
    bwrite(2'd0, 8'hA2, st, acc);
    bwrite(2'd1, 8'h0E, st, acc);
    chk("cfg_stalled", st > 0, 1);
    chk("cfg_accept_cyc", acc, wc_at(b + 1) + 30);
    chk("cfg_en", uart_config_enable, 1);
    chk("cfg_data", uart_config_data, 8'h0E);
    chk("cfg_no_we", uart_write_enable, 0);
    tick();
    bread(2'd2, v);
    chk("status_baud", v, 8'hE4);
    bwrite(2'd0, 8'hB1, st, acc);
    bwrite(2'd0, 8'hB2, st, acc);
    wait_we(b + 4, 3000);
    chk("slow_gap", wc_at(b + 3) - wc_at(b + 2), 1010);
    chk("cfg_count", cf_cyc.size(), cb + 1);
    wait_irq(1500);

    // Asynchronous reset mid-frame
    b = we_cyc.size();
    cb = cf_cyc.size();
    for (int i = 0; i < 4; i++) bwrite(2'd0, 8'(8'hC1 + i), st, acc);
    wait_we(b + 1, 50);
    repeat (5) tick();
    chk("pre_rst_irq", irq_tx_empty, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ready", bus_ready, 1);
    chk("arst_irq", irq_tx_empty, 1);
    chk("arst_rdata", bus_rdata, 0);
    chk("arst_we", uart_write_enable, 0);
    chk("arst_wdata", uart_write_data, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    bread(2'd2, v);
    chk("arst_status", v, 8'hF4);
    repeat (300) tick();
    chk("arst_no_pulses", we_cyc.size(), b + 1);
    chk("arst_no_cfg", cf_cyc.size(), cb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
